// File: rtl/uart_bridge_pkg.sv
// Shared types and helpers for the key/UART byte bridge.
package uart_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_WAIT = 2'd2
    } tx_state_t;

    // Key idx sends (idx+1)*step, truncated to a byte.
    function automatic logic [7:0] key_code(input int unsigned idx, input logic [7:0] step);
        logic [31:0] w_prod;
        w_prod = (idx + 32'd1) * {24'd0, step};
        return w_prod[7:0];
    endfunction

endpackage

// File: rtl/uart_key_bridge_fifo.sv
// Synchronous byte FIFO with combinational head; a push into a full FIFO
// is accepted when a pop happens in the same cycle.
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr,
    input  logic [7:0]               din,
    input  logic                     rd,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_level;
    logic          w_wr_ok;
    logic          w_rd_ok;

    assign full    = (r_level == (AW+1)'(DEPTH));
    assign empty   = (r_level == '0);
    assign w_rd_ok = rd & ~empty;
    assign w_wr_ok = wr & (~full | w_rd_ok);
    assign dout    = r_mem[r_rptr];
    assign level   = r_level;

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_wr_ok) r_wptr <= r_wptr + 1'b1;
            if (w_rd_ok) r_rptr <= r_rptr + 1'b1;
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/uart_key_bridge.sv
// Glue between debounced keys, received-byte history and the uart_hs
// transmitter: key presses and echoes are queued and paced by tx_ready.
module uart_key_bridge
    import uart_bridge_pkg::*;
#(
    parameter int         NKEY       = 4,
    parameter int         HIST       = 3,
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] CODE_STEP  = 8'h11
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic [NKEY-1:0]               key_stable,
    input  logic                          echo_en,
    input  logic                          uart_rec,
    input  logic [7:0]                    uart_data_out,
    input  logic                          tx_ready,
    output logic                          uart_send,
    output logic [7:0]                    uart_data_in,
    output logic [8*HIST-1:0]             hist,
    output logic [15:0]                   rx_count,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level,
    output logic                          ovf,
    input  logic                          ovf_clr
);
    logic [NKEY-1:0]   r_key_prev;
    logic [NKEY-1:0]   r_pending;
    logic              r_armed;
    logic [NKEY-1:0]   w_press;
    logic [NKEY-1:0]   w_clr;
    logic              w_push;
    logic [7:0]        w_push_data;
    logic              w_pop;
    logic [7:0]        w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_drop;
    tx_state_t         r_state;
    tx_state_t         w_state_nxt;
    logic              r_send;
    logic [7:0]        r_data;
    logic [8*HIST-1:0] r_hist;
    logic [8*HIST-1:0] w_hist_nxt;
    logic [15:0]       r_rx_count;
    logic              r_ovf;

    // r_armed masks the first cycle after reset so a key held through reset
    // is captured into r_key_prev rather than reported as a press.
    assign w_press = r_armed ? (r_key_prev & ~key_stable) : '0;

    always_comb begin
        w_push      = 1'b0;
        w_push_data = '0;
        w_clr       = '0;
        if (uart_rec && echo_en) begin
            w_push      = 1'b1;
            w_push_data = uart_data_out;
        end else begin
            for (int i = NKEY - 1; i >= 0; i--) begin
                if (r_pending[i]) begin
                    w_clr       = '0;
                    w_clr[i]    = 1'b1;
                    w_push_data = key_code(i, CODE_STEP);
                end
            end
            w_push = |r_pending;
        end
    end

    assign w_drop = w_push & w_full & ~w_pop;

    generate
        if (HIST > 1) begin : g_hist_shift
            assign w_hist_nxt = {r_hist[8*HIST-9:0], uart_data_out};
        end else begin : g_hist_single
            assign w_hist_nxt = uart_data_out;
        end
    endgenerate

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_key_prev <= '1;
            r_armed    <= 1'b0;
            r_pending  <= '0;
            r_hist     <= '0;
            r_rx_count <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_key_prev <= key_stable;
            r_armed    <= 1'b1;
            r_pending  <= (r_pending & ~w_clr) | w_press;
            if (uart_rec) begin
                r_hist     <= w_hist_nxt;
                r_rx_count <= r_rx_count + 16'd1;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .wr    (w_push),
        .din   (w_push_data),
        .rd    (w_pop),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .level (tx_level)
    );

    // HOLD skips one cycle so the transmitter's busy response is not missed.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty && tx_ready) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (tx_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_IDLE;
            r_send  <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_send  <= w_pop;
            if (w_pop) r_data <= w_head;
        end
    end

    assign uart_send    = r_send;
    assign uart_data_in = r_data;
    assign hist         = r_hist;
    assign rx_count     = r_rx_count;
    assign ovf          = r_ovf;

endmodule

// File: tb/tb_uart_key_bridge.sv
// Directed bench for uart_key_bridge: echo, key presses, ordering,
// overflow, history and reset behaviour.
module tb_uart_key_bridge;
    logic        sys_clk;
    logic        sys_rst_n;
    logic [3:0]  key_stable;
    logic        echo_en;
    logic        uart_rec;
    logic [7:0]  uart_data_out;
    logic        tx_ready;
    logic        uart_send;
    logic [7:0]  uart_data_in;
    logic [23:0] hist;
    logic [15:0] rx_count;
    logic [3:0]  tx_level;
    logic        ovf;
    logic        ovf_clr;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;
    logic [7:0] sent_q[$];
    int         sent_t[$];

    uart_key_bridge #(
        .NKEY       (4),
        .HIST       (3),
        .FIFO_DEPTH (8),
        .CODE_STEP  (8'h11)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .key_stable    (key_stable),
        .echo_en       (echo_en),
        .uart_rec      (uart_rec),
        .uart_data_out (uart_data_out),
        .tx_ready      (tx_ready),
        .uart_send     (uart_send),
        .uart_data_in  (uart_data_in),
        .hist          (hist),
        .rx_count      (rx_count),
        .tx_level      (tx_level),
        .ovf           (ovf),
        .ovf_clr       (ovf_clr)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc++;

    always @(negedge sys_clk) begin
        if (uart_send) begin
            sent_q.push_back(uart_data_in);
            sent_t.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic clear_log();
        sent_q.delete();
        sent_t.delete();
    endtask

    initial begin
        int min_gap;

        sys_rst_n     = 1'b0;
        key_stable    = 4'hF;
        echo_en       = 1'b0;
        uart_rec      = 1'b0;
        uart_data_out = 8'h00;
        tx_ready      = 1'b0;
        ovf_clr       = 1'b0;
        idle(3);
        check("rst_send", {31'd0, uart_send}, 32'd0);
        check("rst_data", {24'd0, uart_data_in}, 32'd0);
        check("rst_hist", {8'd0, hist}, 32'd0);
        check("rst_rxcnt", {16'd0, rx_count}, 32'd0);
        check("rst_level", {28'd0, tx_level}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        sys_rst_n = 1'b1;
        idle(3);

        // 1: echo of a received byte
        clear_log();
        echo_en       = 1'b1;
        tx_ready      = 1'b1;
        uart_rec      = 1'b1;
        uart_data_out = 8'hA5;
        idle(1);
        uart_rec = 1'b0;
        check("t1_hist", {8'd0, hist}, 32'h0000A5);
        check("t1_rxcnt", {16'd0, rx_count}, 32'd1);
        idle(6);
        check("t1_nsent", sent_q.size(), 32'd1);
        if (sent_q.size() >= 1) check("t1_byte", {24'd0, sent_q[0]}, 32'hA5);

        // 2: a held key sends once, a second press sends again
        clear_log();
        key_stable[2] = 1'b0;
        idle(1000);
        check("t2_nsent_hold", sent_q.size(), 32'd1);
        if (sent_q.size() >= 1) check("t2_byte0", {24'd0, sent_q[0]}, 32'h33);
        key_stable[2] = 1'b1;
        idle(5);
        key_stable[2] = 1'b0;
        idle(10);
        key_stable[2] = 1'b1;
        check("t2_nsent_two", sent_q.size(), 32'd2);
        if (sent_q.size() >= 2) check("t2_byte1", {24'd0, sent_q[1]}, 32'h33);
        idle(3);

        // 3: echo and two key presses in one cycle
        clear_log();
        uart_rec      = 1'b1;
        uart_data_out = 8'h5A;
        key_stable    = 4'b0110;
        idle(1);
        uart_rec = 1'b0;
        idle(20);
        key_stable = 4'hF;
        check("t3_nsent", sent_q.size(), 32'd3);
        if (sent_q.size() >= 3) begin
            check("t3_b0", {24'd0, sent_q[0]}, 32'h5A);
            check("t3_b1", {24'd0, sent_q[1]}, 32'h11);
            check("t3_b2", {24'd0, sent_q[2]}, 32'h44);
        end
        idle(3);

        // 4: overflow with the transmitter stalled
        clear_log();
        echo_en  = 1'b0;
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            key_stable[i % 4] = 1'b0;
            idle(1);
            key_stable[i % 4] = 1'b1;
            idle(1);
        end
        idle(3);
        check("t4_level_full", {28'd0, tx_level}, 32'd8);
        check("t4_ovf_set", {31'd0, ovf}, 32'd1);
        check("t4_nsent_stall", sent_q.size(), 32'd0);
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
        check("t4_ovf_clr", {31'd0, ovf}, 32'd0);
        tx_ready = 1'b1;
        idle(40);
        check("t4_nsent", sent_q.size(), 32'd8);
        if (sent_q.size() == 8) begin
            check("t4_first", {24'd0, sent_q[0]}, 32'h11);
            check("t4_fifth", {24'd0, sent_q[4]}, 32'h11);
            check("t4_last", {24'd0, sent_q[7]}, 32'h44);
            min_gap = 1000;
            for (int i = 1; i < 8; i++) begin
                if (sent_t[i] - sent_t[i-1] < min_gap) min_gap = sent_t[i] - sent_t[i-1];
            end
            check("t4_min_gap", min_gap, 32'd3);
        end
        check("t4_level_empty", {28'd0, tx_level}, 32'd0);

        // 5: history of four bytes; counter includes the two earlier receives
        for (int i = 1; i <= 4; i++) begin
            uart_rec      = 1'b1;
            uart_data_out = 8'(i);
            idle(1);
        end
        uart_rec = 1'b0;
        idle(1);
        check("t5_hist", {8'd0, hist}, 32'h020304);
        check("t5_rxcnt", {16'd0, rx_count}, 32'd6);

        // 6: reset with bytes queued and the FSM waiting on tx_ready
        key_stable = 4'h0;
        idle(3);
        tx_ready = 1'b0;
        idle(3);
        check("t6_level_pre", {28'd0, tx_level}, 32'd3);
        sys_rst_n = 1'b0;
        #1;
        check("t6_send", {31'd0, uart_send}, 32'd0);
        check("t6_data", {24'd0, uart_data_in}, 32'd0);
        check("t6_hist", {8'd0, hist}, 32'd0);
        check("t6_rxcnt", {16'd0, rx_count}, 32'd0);
        check("t6_level", {28'd0, tx_level}, 32'd0);
        check("t6_ovf", {31'd0, ovf}, 32'd0);
        idle(2);
        clear_log();
        tx_ready  = 1'b1;
        sys_rst_n = 1'b1;
        idle(20);
        check("t6_nsent_after", sent_q.size(), 32'd0);
        check("t6_level_after", {28'd0, tx_level}, 32'd0);
        key_stable = 4'hF;
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
